// File: rtl/load_store_unit.sv
// Byte-serial RV32 load/store unit: one memory byte per cycle, RESP N+1 cycles after accept.
// Optional macro LSU_MISALIGN_EN lets H/W accesses use any address (bytes wrap modulo memory depth).
module load_store_unit #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_wr_add,
  output logic [ADDR_W-1:0] mem_rd_add,
  output logic [31:0]       mem_wr_data,
  output logic              mem_sw,
  input  logic [31:0]       mem_data_in
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] acc_addr;
  logic [1:0]        cnt;
  logic [1:0]        last_cnt;
  logic [23:0]       wdata_sh;
  logic [7:0]        wr_byte;
  logic [31:0]       ld_buf;
  logic [31:0]       ld_next;
  logic [31:0]       ld_ext;
  logic              bad_code;
  logic              misalign;
  logic              req_err;
  logic              unused_hi;

  assign req_ready   = (state == IDLE);
  assign mem_wr_add  = acc_addr;
  assign mem_rd_add  = acc_addr;
  assign mem_wr_data = {24'b0, wr_byte};
  assign unused_hi   = ^mem_data_in[31:8];

  always_comb begin
    bad_code = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
               (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
`ifdef LSU_MISALIGN_EN
    misalign = 1'b0;
`else
    misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`endif
    req_err = bad_code || misalign;
  end

  always_comb begin
    case (f3_q[1:0])
      2'b00:   last_cnt = 2'd0;
      2'b01:   last_cnt = 2'd1;
      default: last_cnt = 2'd3;
    endcase
  end

  // Merge the byte arriving this cycle so the final result is ready on the last ACCESS edge.
  always_comb begin
    ld_next = ld_buf;
    case (cnt)
      2'd0:    ld_next[7:0]   = mem_data_in[7:0];
      2'd1:    ld_next[15:8]  = mem_data_in[7:0];
      2'd2:    ld_next[23:16] = mem_data_in[7:0];
      default: ld_next[31:24] = mem_data_in[7:0];
    endcase
  end

  always_comb begin
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_next[7]}}, ld_next[7:0]};
      3'b001:  ld_ext = {{16{ld_next[15]}}, ld_next[15:0]};
      3'b100:  ld_ext = {24'b0, ld_next[7:0]};
      3'b101:  ld_ext = {16'b0, ld_next[15:0]};
      default: ld_ext = ld_next;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      acc_addr   <= '0;
      cnt        <= 2'd0;
      wdata_sh   <= 24'b0;
      wr_byte    <= 8'b0;
      ld_buf     <= 32'b0;
      mem_sw     <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'b0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            we_q       <= req_we;
            f3_q       <= req_funct3;
            acc_addr   <= req_addr;
            cnt        <= 2'd0;
            wr_byte    <= req_wdata[7:0];
            wdata_sh   <= req_wdata[31:8];
            ld_buf     <= 32'b0;
            resp_rdata <= 32'b0;
            if (req_err) begin
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              resp_err <= 1'b0;
              mem_sw   <= req_we;
              state    <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!we_q) ld_buf <= ld_next;
          if (cnt == last_cnt) begin
            mem_sw     <= 1'b0;
            resp_valid <= 1'b1;
            if (!we_q) resp_rdata <= ld_ext;
            state      <= RESP;
          end else begin
            cnt      <= cnt + 2'd1;
            acc_addr <= acc_addr + ADDR_W'(1);
            wr_byte  <= wdata_sh[7:0];
            wdata_sh <= {8'b0, wdata_sh[23:8]};
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-wide memory model plus expected response/write queues.
module tb_load_store_unit;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    int         addr;
    logic [7:0] data;
  } wexp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = 3'b000;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'b0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_wr_add;
  logic [ADDR_W-1:0] mem_rd_add;
  logic [31:0]       mem_wr_data;
  logic              mem_sw;
  logic [31:0]       mem_data_in;

  logic [7:0] dmem    [0:DEPTH-1];
  logic [7:0] ref_mem [0:DEPTH-1];
  exp_t       sb[$];
  wexp_t      wq[$];
  int         cyc = 0;
  int         acc_cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_wr_add(mem_wr_add), .mem_rd_add(mem_rd_add), .mem_wr_data(mem_wr_data),
    .mem_sw(mem_sw), .mem_data_in(mem_data_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_data_in = {24'b0, dmem[mem_rd_add]};
  always @(posedge clk) if (mem_sw) dmem[mem_wr_add] <= mem_wr_data[7:0];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Response scoreboard
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) chk("spurious_resp", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("rdata", resp_rdata, e.rdata);
        chk("err", {31'b0, resp_err}, {31'b0, e.err});
        chk("latency", cyc - acc_cyc, e.lat);
      end
    end
  end

  // Memory write scoreboard
  always @(negedge clk) begin
    if (mem_sw) begin
      if (wq.size() == 0) chk("spurious_write", 32'd1, 32'd0);
      else begin
        wexp_t w;
        w = wq.pop_front();
        chk("wr_add", {27'b0, mem_wr_add}, w.addr);
        chk("wr_data", mem_wr_data, {24'b0, w.data});
      end
    end
  end

  // Reference model: pushes expected response and byte writes
  task automatic model(input logic we, input logic [2:0] f3, input int addr, input logic [31:0] wdata);
    int n;
    logic err;
    logic [31:0] r;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    err = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
`ifndef LSU_MISALIGN_EN
    if (n == 2 && (addr % 2) != 0) err = 1'b1;
    if (n == 4 && (addr % 4) != 0) err = 1'b1;
`endif
    r = 32'b0;
    if (err) begin
      sb.push_back('{rdata: 32'b0, err: 1'b1, lat: 1});
    end else if (we) begin
      for (int k = 0; k < n; k++) begin
        wq.push_back('{addr: (addr + k) % DEPTH, data: wdata[8*k +: 8]});
        ref_mem[(addr + k) % DEPTH] = wdata[8*k +: 8];
      end
      sb.push_back('{rdata: 32'b0, err: 1'b0, lat: n + 1});
    end else begin
      for (int k = 0; k < n; k++) r[8*k +: 8] = ref_mem[(addr + k) % DEPTH];
      case (f3)
        3'b000: r = {{24{r[7]}}, r[7:0]};
        3'b001: r = {{16{r[15]}}, r[15:0]};
        default: ;
      endcase
      sb.push_back('{rdata: r, err: 1'b0, lat: n + 1});
    end
  endtask

  task automatic send(input logic we, input logic [2:0] f3, input int addr, input logic [31:0] wdata,
                      output int acc);
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = ADDR_W'(addr);
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    acc = cyc - 1;
    acc_cyc = acc;
    req_valid = 1'b0;
  endtask

  task automatic op(input logic we, input logic [2:0] f3, input int addr, input logic [31:0] wdata);
    int a;
    model(we, f3, addr, wdata);
    send(we, f3, addr, wdata, a);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (sb.size() != 0 || wq.size() != 0); i++) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    chk("wq_empty", wq.size(), 32'd0);
  endtask

  initial begin
    int a1, a2, a3, a4;
    for (int i = 0; i < DEPTH; i++) begin
      dmem[i]    = 8'(i);
      ref_mem[i] = 8'(i);
    end
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_mem_sw", {31'b0, mem_sw}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'b0, resp_err}, 32'd0);
    chk("rst_addr", {27'b0, mem_wr_add}, 32'd0);
    rst = 1'b0;

    op(1'b0, 3'b010, 4, 32'h0);                 // LW 4 -> 0x07060504
    drain();
    op(1'b1, 3'b010, 8, 32'hDEADBEEF);
    op(1'b0, 3'b010, 8, 32'h0);
    drain();
    op(1'b1, 3'b000, 3, 32'h00000080);
    op(1'b0, 3'b000, 3, 32'h0);
    op(1'b0, 3'b100, 3, 32'h0);
    drain();
    op(1'b0, 3'b010, 6, 32'h0);                 // misaligned word
    op(1'b0, 3'b001, 31, 32'h0);                // halfword wrapping past top
    drain();

    // Abort a word store after two bytes
    wq.push_back('{addr: 12, data: 8'h44});
    wq.push_back('{addr: 13, data: 8'h33});
    ref_mem[12] = 8'h44;
    ref_mem[13] = 8'h33;
    send(1'b1, 3'b010, 12, 32'h11223344, a1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_mem_sw", {31'b0, mem_sw}, 32'd0);
    chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_b12", {24'b0, dmem[12]}, 32'h44);
    chk("abort_b13", {24'b0, dmem[13]}, 32'h33);
    chk("abort_b14", {24'b0, dmem[14]}, 32'd14);
    chk("abort_b15", {24'b0, dmem[15]}, 32'd15);
    drain();

    // Illegal codes and back-to-back acceptance
    model(1'b0, 3'b011, 0, 32'h0);
    send(1'b0, 3'b011, 0, 32'h0, a1);
    model(1'b0, 3'b010, 0, 32'h0);
    send(1'b0, 3'b010, 0, 32'h0, a2);
    chk("b2b_after_err", a2 - a1, 32'd2);
    model(1'b1, 3'b100, 20, 32'hCAFEF00D);
    send(1'b1, 3'b100, 20, 32'hCAFEF00D, a3);
    chk("b2b_after_lw", a3 - a2, 32'd6);
    model(1'b0, 3'b100, 5, 32'h0);
    send(1'b0, 3'b100, 5, 32'h0, a4);
    chk("b2b_after_store_err", a4 - a3, 32'd2);
    drain();

    for (int i = 0; i < 40; i++)
      op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom_range(0, DEPTH - 1), $urandom);
    drain();

    for (int i = 0; i < DEPTH; i++) chk("final_mem", {24'b0, dmem[i]}, {24'b0, ref_mem[i]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: ADDR_W, default 5, byte-address width of the data memory (depth 2**ADDR_W bytes).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: req_valid  input  1  request present.
REQ-005 SHALL have port: req_ready  output  1  unit idle, request accepted when req_valid && req_ready at rising edge.
REQ-006 SHALL have port: req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: req_funct3  input  3  RV32 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port: req_addr  input  ADDR_W  byte address.
REQ-009 SHALL have port: req_wdata  input  32  store data, little-endian.
REQ-010 SHALL have port: resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: resp_rdata  output  32  load result, valid with resp_valid.
REQ-012 SHALL have port: resp_err  output  1  illegal/misaligned request, valid with resp_valid.
REQ-013 SHALL have port: mem_wr_add, mem_rd_add  output  ADDR_W  byte addresses to data memory.
REQ-014 SHALL have port: mem_wr_data  output  32  byte in [7:0], [31:8] = 0.
REQ-015 SHALL have port: mem_sw  output  1  byte write strobe to data memory.
REQ-016 SHALL have port: mem_data_in  input  32  combinational read data from data memory, only [7:0] used.

Function
REQ-017 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; req_ready = 1 only in IDLE.
REQ-018 SHALL latch we, funct3, addr, wdata on acceptance; inputs ignored outside IDLE.
REQ-019 SHALL set byte count N = 1 (B/BU), 2 (H/HU), 4 (W); byte k accessed at (addr + k) mod 2**ADDR_W, k = 0..N-1, one byte per cycle in ACCESS.
REQ-020 SHALL, for store byte k: mem_sw = 1, mem_wr_add = addr+k, mem_wr_data = {24'b0, wdata[8k+7:8k]}.
REQ-021 SHALL, for load byte k: mem_rd_add = addr+k, capture mem_data_in[7:0] into result byte k at the cycle's rising edge; mem_sw = 0.
REQ-022 SHALL hold mem_sw = 0 in every cycle that is not an ACCESS store cycle.
REQ-023 SHALL sign-extend B/H results from bit 7/15, zero-extend BU/HU; W unextended; resp_rdata = 0 for stores and errors.
REQ-024 SHALL assert resp_valid in the single RESP cycle, i.e. N+1 cycles after acceptance; resp_rdata/resp_err held until next acceptance.
REQ-025 SHALL flag error for funct3 in {011, 110, 111}, for store funct3 in {100, 101}, and for misalignment (see REQ-030): go IDLE -> RESP directly, resp_err = 1, no memory access.
REQ-026 SHALL accept a new request in the IDLE cycle immediately following RESP (no extra bubble).

Reset
REQ-027 SHALL, on rst asserted at any time, force state IDLE, byte counter 0, mem_sw 0, resp_valid 0, resp_err 0, resp_rdata 0, mem addresses 0, req_ready 1, without waiting for clk.
REQ-028 SHALL abort an in-flight access on reset; bytes already stored remain written, no response issued.

Configuration
REQ-029 SHALL use macro LSU_MISALIGN_EN to compile misaligned-access support in or out.
REQ-030 SHALL, without LSU_MISALIGN_EN: H/HU with addr[0] != 0 or W with addr[1:0] != 0 -> error per REQ-025; with LSU_MISALIGN_EN: any address accepted, bytes wrap modulo 2**ADDR_W per REQ-019, never flagged.

Verification
REQ-031 SHALL cover: after reset (memory byte i = i), LW addr 4 -> resp_valid 5 cycles after accept, resp_rdata 0x07060504, resp_err 0.
REQ-032 SHALL cover: SW 0xDEADBEEF addr 8 -> mem_sw high 4 cycles, addr 8..11, data 0xEF, 0xBE, 0xAD, 0xDE; then LW 8 -> 0xDEADBEEF.
REQ-033 SHALL cover: SB 0x00000080 addr 3, then LB 3 -> 0xFFFFFF80, LBU 3 -> 0x00000080.
REQ-034 SHALL cover: without LSU_MISALIGN_EN, LW addr 6 -> resp_valid 1 cycle after accept, resp_err 1, resp_rdata 0, mem_sw never high; with macro, LH addr 31 -> 0x0000001F (bytes 31, 0).
REQ-035 SHALL cover: SW 0x11223344 addr 12, rst asserted after 2 store cycles -> bytes 12/13 = 0x44/0x33, bytes 14/15 unchanged, no resp_valid, req_ready 1 immediately.
REQ-036 SHALL cover: funct3 011 load and funct3 100 store -> resp_err 1, no memory access; back-to-back request accepted in cycle after RESP.
